// File: rtl/instr_fetch_queue.sv
// Instruction queue between fetch and decode. A small FIFO sits behind a
// registered output stage that feeds decode. Decode stalls are absorbed
// without losing fetch data. Branch/jump delay slots are tagged, and a
// pipeline flush drains the queue and the output stage to NOP.
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        if_valid_i,
  input  logic [31:0] if_pc_i,
  input  logic [31:0] if_instr_i,
  input  logic        if_adel_i,
  output logic        if_ready_o,
  input  logic        id_stall_i,
  input  logic        id_ctrl_flow_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o,
  output logic        id_adel_o,
  output logic        id_in_ds_o
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [31:0] fifo_pc    [DEPTH];
  logic [31:0] fifo_instr [DEPTH];
  logic        fifo_adel  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          ds_pending;

  logic push_ok;
  logic adv;
  logic consume;
  logic fifo_empty;
  logic fifo_rd;
  logic bypass;
  logic fifo_wr;
  logic ds_now;

  // Ready depends only on occupancy, so decode stall never reaches fetch combinationally
  assign if_ready_o = (count != FULL_COUNT);
  assign push_ok    = if_valid_i & if_ready_o & ~flush_i;
  assign adv        = ~id_valid_o | ~id_stall_i;
  assign consume    = id_valid_o & ~id_stall_i;
  assign fifo_empty = (count == '0);
  assign fifo_rd    = adv & ~fifo_empty & ~flush_i;
  assign bypass     = adv & fifo_empty & push_ok;
  assign fifo_wr    = push_ok & ~bypass & ~rst;
  // A branch leaving the output this cycle makes whatever loads now its delay slot
  assign ds_now     = ds_pending | (consume & id_ctrl_flow_i);

  // Storage array; only the pointers and count need clearing on reset or flush
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_pc[wr_ptr]    <= if_pc_i;
      fifo_instr[wr_ptr] <= if_instr_i;
      fifo_adel[wr_ptr]  <= if_adel_i;
    end
  end

  // Pointer, occupancy, output stage and delay-slot tracking
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ds_pending <= 1'b0;
      id_valid_o <= 1'b0;
      id_pc_o    <= '0;
      id_instr_o <= '0;
      id_adel_o  <= 1'b0;
      id_in_ds_o <= 1'b0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (fifo_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (adv) begin
        if (fifo_rd) begin
          id_valid_o <= 1'b1;
          id_pc_o    <= fifo_pc[rd_ptr];
          id_instr_o <= fifo_instr[rd_ptr];
          id_adel_o  <= fifo_adel[rd_ptr];
          id_in_ds_o <= ds_now;
          ds_pending <= 1'b0;
        end else if (bypass) begin
          id_valid_o <= 1'b1;
          id_pc_o    <= if_pc_i;
          id_instr_o <= if_instr_i;
          id_adel_o  <= if_adel_i;
          id_in_ds_o <= ds_now;
          ds_pending <= 1'b0;
        end else begin
          id_valid_o <= 1'b0;
          id_pc_o    <= '0;
          id_instr_o <= '0;
          id_adel_o  <= 1'b0;
          id_in_ds_o <= 1'b0;
          ds_pending <= ds_now;
        end
      end
    end
  end

endmodule
